// File: rtl/sos_cmd_sequencer_if.sv
// Request, issue and status signals between the key/host logic, the command
// sequencer and the SOS pattern generator.
interface sos_cmd_sequencer_if;
  logic [3:0] req_sig;
  logic       en_in;
  logic       flush_sig;
  logic       cmd_done_sig;
  logic [3:0] cmd_start_sig;
  logic       func_en_sig;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow_sig;
  logic       timeout_sig;

  modport master (
    input  req_sig, en_in, flush_sig, cmd_done_sig,
    output cmd_start_sig, func_en_sig, busy, fifo_full, fifo_empty,
           overflow_sig, timeout_sig
  );

  modport slave (
    output req_sig, en_in, flush_sig, cmd_done_sig,
    input  cmd_start_sig, func_en_sig, busy, fifo_full, fifo_empty,
           overflow_sig, timeout_sig
  );
endinterface

// File: rtl/sos_cmd_sequencer.sv
// Queues request pulses and issues them one at a time as one-hot commands with an
// inter-command gap. Define CMD_SEQ_TIMEOUT_EN to enable the WAIT-state watchdog.
module sos_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned CNT_W          = 26
) (
  input logic                 CLK,
  input logic                 RST,
  sos_cmd_sequencer_if.master bus
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
`ifdef CMD_SEQ_TIMEOUT_EN
  localparam int unsigned TO_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
`endif

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      int'($clog2(GAP_CYCLES + 1)) > int'(CNT_W) ||
      int'($clog2(TIMEOUT_CYCLES + 1)) > int'(CNT_W)) begin : g_param_check
    $error("sos_cmd_sequencer: invalid parameter set");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, func_en_q;

  logic [1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ, occ_d;
  logic             full_q, empty_q, overflow_q;

  logic [1:0]       req_code;
  logic             push_req, push_ok, pop, dropped;

  // Multi-hot requests resolve to the lowest set bit
  always_comb begin
    req_code = 2'd0;
    if (bus.req_sig[0])      req_code = 2'd0;
    else if (bus.req_sig[1]) req_code = 2'd1;
    else if (bus.req_sig[2]) req_code = 2'd2;
    else if (bus.req_sig[3]) req_code = 2'd3;
  end

  assign push_req = |bus.req_sig;
  assign pop      = (state_q == ST_IDLE) && bus.en_in && !empty_q;
  assign push_ok  = push_req && !bus.flush_sig && (!full_q || pop);
  assign dropped  = push_req && !bus.flush_sig && full_q && !pop;

  always_comb begin
    occ_d = occ;
    if (bus.flush_sig)
      occ_d = '0;
    else if (push_ok && !pop)
      occ_d = occ + OCC_W'(1);
    else if (pop && !push_ok)
      occ_d = occ - OCC_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      occ        <= occ_d;
      full_q     <= (occ_d == OCC_W'(FIFO_DEPTH));
      empty_q    <= (occ_d == '0);
      overflow_q <= dropped;
      if (bus.flush_sig) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Queue storage needs no reset; occupancy alone defines valid entries
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= req_code;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          cmd_d   = 4'b0001 << mem[rd_ptr];
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.cmd_done_sig) begin
          cmd_d   = 4'b0000;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
`ifdef CMD_SEQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TO_LAST)) begin
          cmd_d     = 4'b0000;
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // busy/func_en are registered from the next state so they track the current state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= 4'b0000;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      func_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d != ST_IDLE);
      func_en_q <= bus.en_in || (state_d != ST_IDLE);
    end
  end

  assign bus.cmd_start_sig = cmd_q;
  assign bus.func_en_sig   = func_en_q;
  assign bus.busy          = busy_q;
  assign bus.fifo_full     = full_q;
  assign bus.fifo_empty    = empty_q;
  assign bus.overflow_sig  = overflow_q;
  assign bus.timeout_sig   = timeout_q;

endmodule

// File: tb/tb_sos_cmd_sequencer.sv
// Bench for sos_cmd_sequencer: directed scenarios plus random traffic against a
// queue-based reference model. Honours CMD_SEQ_TIMEOUT_EN like the design.
module tb_sos_cmd_sequencer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 5;
  localparam int unsigned TO    = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  sos_cmd_sequencer_if bus ();

  sos_cmd_sequencer #(
    .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .CNT_W(26)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of codes, the active code, and countdowns
  int         q[$];
  int         active = -1;
  int         gap_left = 0;
  int         wait_n = 0;
  logic [3:0] m_cmd = 4'd0;
  logic       m_busy = 1'b0, m_fen = 1'b0, m_full = 1'b0, m_empty = 1'b1;
  logic       m_ovf = 1'b0, m_to = 1'b0;
  bit         model_on = 1'b0;

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      active = -1; gap_left = 0; wait_n = 0;
      m_cmd = 4'd0; m_busy = 1'b0; m_fen = 1'b0; m_full = 1'b0;
      m_empty = 1'b1; m_ovf = 1'b0; m_to = 1'b0;
    end else begin : step
      bit idle, pop, full;
      int code, head;
      idle = (active < 0) && (gap_left == 0);
      full = (q.size() == DEPTH);
      pop  = idle && bus.en_in && (q.size() != 0);
      code = lowest(bus.req_sig);
      head = pop ? q[0] : -1;
      m_ovf = (code >= 0) && full && !pop && !bus.flush_sig;
      m_to  = 1'b0;
      if (bus.flush_sig) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (code >= 0 && (!full || pop)) q.push_back(code);
      end
      if (idle) begin
        if (pop) begin active = head; wait_n = 0; end
      end else if (active >= 0) begin
        if (bus.cmd_done_sig) begin active = -1; gap_left = GAP; end
`ifdef CMD_SEQ_TIMEOUT_EN
        else if (wait_n == int'(TO) - 1) begin active = -1; gap_left = GAP; m_to = 1'b1; end
`endif
        else wait_n++;
      end else begin
        gap_left--;
      end
      m_cmd   = (active >= 0) ? 4'(1 << active) : 4'd0;
      m_busy  = !((active < 0) && (gap_left == 0));
      m_fen   = bus.en_in || m_busy;
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
    end
  end

  always @(negedge CLK) begin
    if (model_on) begin
      chk("cmd_start_sig", 32'(bus.cmd_start_sig), 32'(m_cmd));
      chk("func_en_sig",   32'(bus.func_en_sig),   32'(m_fen));
      chk("busy",          32'(bus.busy),          32'(m_busy));
      chk("fifo_full",     32'(bus.fifo_full),     32'(m_full));
      chk("fifo_empty",    32'(bus.fifo_empty),    32'(m_empty));
      chk("overflow_sig",  32'(bus.overflow_sig),  32'(m_ovf));
      chk("timeout_sig",   32'(bus.timeout_sig),   32'(m_to));
    end
  end

  // Stimulus helpers; inputs change 2 time units after the rising edge
  logic [3:0] issued[$];
  logic [3:0] prev_cmd = 4'd0;
  logic [3:0] exp_ord[5];
  int         w = 0;
  int         dly = 3;
  bit         rnd = 1'b0;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // Acts as the consumer: pulses done a set number of cycles into each command
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (bus.cmd_start_sig != 4'd0) begin
        if (prev_cmd == 4'd0) begin
          issued.push_back(bus.cmd_start_sig);
          w = 0;
          dly = rnd ? int'($urandom_range(0, 20)) : 3;
        end
        bus.cmd_done_sig = (w == dly);
        w++;
      end else begin
        bus.cmd_done_sig = rnd && ($urandom_range(0, 29) == 0);
      end
      prev_cmd = bus.cmd_start_sig;
      if (rnd) begin
        bus.req_sig   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
        bus.flush_sig = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 49) == 0) bus.en_in = !bus.en_in;
      end
      cyc(1);
    end
    bus.cmd_done_sig = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(bus.busy == 1'b0 && bus.fifo_empty == 1'b1 && bus.cmd_start_sig == 4'd0) && k < 400) begin
      run(1);
      k++;
    end
    chk("wait_idle_bound", 32'(k < 400), 32'd1);
  endtask

  initial begin : main
    int zeros;
    bus.req_sig = 4'd0; bus.en_in = 1'b0; bus.flush_sig = 1'b0; bus.cmd_done_sig = 1'b0;
    #1 RST = 1'b1;
    #1;
    chk("rst_cmd", 32'(bus.cmd_start_sig), 32'd0);
    chk("rst_func_en", 32'(bus.func_en_sig), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_full", 32'(bus.fifo_full), 32'd0);
    chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
    chk("rst_ovf", 32'(bus.overflow_sig), 32'd0);
    chk("rst_to", 32'(bus.timeout_sig), 32'd0);
    model_on = 1'b1;
    cyc(2);
    RST = 1'b0;
    cyc(1);

    // Single command: issue latency, done, gap length to the next issue
    bus.en_in = 1'b1; bus.req_sig = 4'b0010;
    cyc(1);
    bus.req_sig = 4'd0;
    chk("t1_empty_t1", 32'(bus.fifo_empty), 32'd0);
    chk("t1_cmd_t1", 32'(bus.cmd_start_sig), 32'd0);
    cyc(1);
    chk("t1_cmd_t2", 32'(bus.cmd_start_sig), 32'b0010);
    chk("t1_busy_t2", 32'(bus.busy), 32'd1);
    cyc(5);
    bus.cmd_done_sig = 1'b1; bus.req_sig = 4'b0001;
    cyc(1);
    bus.cmd_done_sig = 1'b0; bus.req_sig = 4'd0;
    chk("t1_cmd_after_done", 32'(bus.cmd_start_sig), 32'd0);
    zeros = 0;
    while (bus.cmd_start_sig == 4'd0 && zeros < 50) begin zeros++; cyc(1); end
    chk("t1_gap_len", 32'(zeros), 32'(GAP + 1));
    chk("t1_second_cmd", 32'(bus.cmd_start_sig), 32'b0001);
    prev_cmd = 4'd0;
    wait_idle();

    // Fill with en_in low, overflow on the fifth, then drain in order
    bus.en_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.req_sig = 4'(1 << (i % 4));
      cyc(1);
      if (i == 3) chk("t2_full_after_4", 32'(bus.fifo_full), 32'd1);
    end
    bus.req_sig = 4'd0;
    chk("t2_ovf_pulse", 32'(bus.overflow_sig), 32'd1);
    cyc(1);
    chk("t2_ovf_single", 32'(bus.overflow_sig), 32'd0);
    issued.delete();
    bus.en_in = 1'b1;
    run(80);
    exp_ord[0] = 4'b0001; exp_ord[1] = 4'b0010; exp_ord[2] = 4'b0100; exp_ord[3] = 4'b1000;
    chk("t2_issue_count", 32'(issued.size()), 32'd4);
    for (int i = 0; i < 4 && i < issued.size(); i++) chk("t2_issue_order", 32'(issued[i]), 32'(exp_ord[i]));
    wait_idle();

    // Multi-hot request resolves to the lowest set bit
    bus.req_sig = 4'b1010;
    cyc(1);
    bus.req_sig = 4'd0;
    cyc(1);
    chk("t3_multihot", 32'(bus.cmd_start_sig), 32'b0010);
    wait_idle();

    // Full queue popped and pushed in the same cycle
    bus.en_in = 1'b0;
    for (int i = 3; i >= 0; i--) begin bus.req_sig = 4'(1 << i); cyc(1); end
    issued.delete();
    bus.en_in = 1'b1; bus.req_sig = 4'b0100;
    cyc(1);
    bus.req_sig = 4'd0;
    chk("t4_no_ovf", 32'(bus.overflow_sig), 32'd0);
    chk("t4_still_full", 32'(bus.fifo_full), 32'd1);
    chk("t4_first_cmd", 32'(bus.cmd_start_sig), 32'b1000);
    run(150);
    exp_ord[0] = 4'b1000; exp_ord[1] = 4'b0100; exp_ord[2] = 4'b0010; exp_ord[3] = 4'b0001;
    exp_ord[4] = 4'b0100;
    chk("t4_issue_count", 32'(issued.size()), 32'd5);
    for (int i = 0; i < 5 && i < issued.size(); i++) chk("t4_issue_order", 32'(issued[i]), 32'(exp_ord[i]));
    wait_idle();

    // Asynchronous reset while a command is active
    for (int i = 0; i < 3; i++) begin bus.req_sig = 4'(1 << i); cyc(1); end
    bus.req_sig = 4'd0;
    chk("t5_active_before_rst", 32'(bus.cmd_start_sig), 32'b0001);
    #1 RST = 1'b1;
    #1;
    chk("t5_rst_cmd_async", 32'(bus.cmd_start_sig), 32'd0);
    chk("t5_rst_empty", 32'(bus.fifo_empty), 32'd1);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    cyc(2);
    RST = 1'b0;
    prev_cmd = 4'd0;
    cyc(1);

    // Flush during WAIT keeps the active command and empties the queue
    for (int i = 0; i < 3; i++) begin bus.req_sig = 4'(1 << i); cyc(1); end
    bus.req_sig = 4'd0; bus.flush_sig = 1'b1;
    cyc(1);
    bus.flush_sig = 1'b0;
    chk("t5_flush_cmd_kept", 32'(bus.cmd_start_sig), 32'b0001);
    chk("t5_flush_empty", 32'(bus.fifo_empty), 32'd1);
    issued.delete();
    prev_cmd = 4'd0;
    run(40);
    chk("t5_flush_issue_count", 32'(issued.size()), 32'd1);
    wait_idle();

    // No done: watchdog expiry, or indefinite hold without it
    bus.req_sig = 4'b1000;
    cyc(1);
    bus.req_sig = 4'd0;
    cyc(1);
    chk("t6_cmd_start", 32'(bus.cmd_start_sig), 32'b1000);
`ifdef CMD_SEQ_TIMEOUT_EN
    cyc(15);
    chk("t6_before_expiry_cmd", 32'(bus.cmd_start_sig), 32'b1000);
    chk("t6_before_expiry_to", 32'(bus.timeout_sig), 32'd0);
    cyc(1);
    chk("t6_expiry_cmd", 32'(bus.cmd_start_sig), 32'd0);
    chk("t6_expiry_to", 32'(bus.timeout_sig), 32'd1);
    cyc(1);
    chk("t6_to_single", 32'(bus.timeout_sig), 32'd0);
`else
    cyc(1100);
    chk("t6_hold_cmd", 32'(bus.cmd_start_sig), 32'b1000);
    chk("t6_hold_busy", 32'(bus.busy), 32'd1);
    bus.cmd_done_sig = 1'b1;
    cyc(1);
    bus.cmd_done_sig = 1'b0;
    chk("t6_done_clears", 32'(bus.cmd_start_sig), 32'd0);
`endif
    prev_cmd = 4'd0;
    wait_idle();

    // Random traffic against the model
    rnd = 1'b1;
    run(3000);
    rnd = 1'b0;
    bus.req_sig = 4'd0; bus.flush_sig = 1'b0; bus.en_in = 1'b1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sos_cmd_sequencer.md
Name: sos_cmd_sequencer

Overview:
- Upstream command issuer for the SOS pattern generator stage.
- Accepts request pulses from debounced keys or a host and queues them in a small FIFO.
- Issues one command at a time as a one-hot 4-bit start, holds it until the consumer's done pulse, then waits an inter-command gap before issuing the next.
- Its outputs drive the consumer's func_en_sig and cmd_start_sig; its input cmd_done_sig comes from the consumer's done output.

Parameters:
FIFO_DEPTH, 4, command queue depth; power of 2, at least 2
GAP_CYCLES, 1000, idle cycles between done and the next issue; 0 means no gap
TIMEOUT_CYCLES, 50000000, WAIT-state watchdog limit; used only with CMD_SEQ_TIMEOUT_EN
CNT_W, 26, counter width; must hold max(GAP_CYCLES, TIMEOUT_CYCLES)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-high reset
req_sig  input  4  request pulses, one per command code; multi-hot resolves to the lowest set bit
en_in  input  1  enable switch; allows new issues
flush_sig  input  1  synchronous FIFO clear
cmd_done_sig  input  1  single-cycle done pulse from the consumer
cmd_start_sig  output  4  one-hot command, held until done
func_en_sig  output  1  consumer enable
busy  output  1  high when the FSM is not in IDLE
fifo_full  output  1  queue full
fifo_empty  output  1  queue empty
overflow_sig  output  1  one-cycle pulse when a request is dropped
timeout_sig  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- One clock domain: CLK. Reset is asynchronous and active-high on RST.
- Reset values: cmd_start_sig=0, func_en_sig=0, busy=0, fifo_full=0, fifo_empty=1, overflow_sig=0, timeout_sig=0. FSM=IDLE, FIFO pointers=0, counters=0.
- Reset mid-operation: cmd_start_sig drops immediately (asynchronously), queued commands are lost, FSM returns to IDLE.
- Push:
  - When req_sig!=0, the index of the lowest set bit (2 bits) is written at that edge.
  - Written only if the FIFO is not full, or if it is full and a pop occurs in the same cycle; count is then unchanged.
  - Otherwise the request is dropped and overflow_sig pulses on the next cycle.
- FIFO structure: binary read/write pointers with modulo-FIFO_DEPTH wrap plus an occupancy count (range 0..FIFO_DEPTH). fifo_full and fifo_empty are registered from that count.
- Simultaneous push and pop on a non-empty FIFO: both take effect, count unchanged.
- flush_sig: pointers and count cleared at the edge and overrides a same-cycle push. Does not affect an active command.
- FSM states IDLE, WAIT, GAP:
  - IDLE: if en_in=1 and fifo_empty=0, pop the head at the edge, load cmd_start_sig = 1<<index, go to WAIT.
  - WAIT: cmd_start_sig holds. On cmd_done_sig=1, clear cmd_start_sig at that edge, clear the counter, go to GAP (or straight to IDLE if GAP_CYCLES=0).
  - GAP: counter increments each cycle; when counter==GAP_CYCLES-1, go to IDLE.
  - cmd_done_sig outside WAIT is ignored.
- Latency: a request in cycle t is visible as non-empty in t+1; with IDLE and en_in=1, cmd_start_sig is asserted from t+2.
- func_en_sig is registered: en_in, OR'd with (state!=IDLE). en_in falling during WAIT or GAP does not abort; the current command completes and no further pops occur.
- busy is registered: state!=IDLE.

Optional Feature:
- Macro CMD_SEQ_TIMEOUT_EN.
- Defined:
  - In WAIT, a counter increments from 0.
  - If it reaches TIMEOUT_CYCLES-1 with no cmd_done_sig: cmd_start_sig clears, timeout_sig pulses one cycle, FSM goes to GAP.
  - A cmd_done_sig in the expiry cycle takes priority; no timeout_sig.
- Undefined: WAIT holds indefinitely; timeout_sig is tied to 0.

Test Plan:
- Reset, en_in=1, req_sig=4'b0010 for one cycle at t -> cmd_start_sig=4'b0010 from t+2. Done pulse 5 cycles later -> cmd_start_sig=0 next cycle; next issue no earlier than GAP_CYCLES cycles after.
- Push 5 requests (codes 0,1,2,3,0) with en_in=0, FIFO_DEPTH=4 -> fifo_full=1 after the 4th; overflow_sig pulse for the 5th. Set en_in=1 -> issues in order 0001,0010,0100,1000.
- req_sig=4'b1010 -> queued code 1; cmd_start_sig=4'b0010.
- Full FIFO while IDLE popping, with a push in the same cycle -> no overflow_sig, count stays 4, order preserved.
- RST asserted during WAIT -> cmd_start_sig=0 without a clock edge; FIFO empty. flush_sig during WAIT -> active command continues, queue empty afterwards.
- With CMD_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: no done -> timeout_sig pulse and cmd_start_sig=0 after 16 WAIT cycles. Without the macro: cmd_start_sig holds beyond 1000 cycles.
